tdm_slot_deserializer: RTL

//  Receive-side stage fed by the bit-clock-registered expansion TDM input (one x_tdmin lane).

---
 rtl/tdm_slot_deserializer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tdm_slot_deserializer.sv
// TDM slot deserializer: locks to the lrck frame sync and turns one serial
// expansion lane into slot-tagged parallel words.
module tdm_slot_deserializer #(
  parameter int SLOT_BITS   = 32,
  parameter int SLOTS       = 8,
  parameter int FSYNC_DELAY = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                     clkin,
  input  logic                     rst,
  input  logic                     lrck,
  input  logic                     sdin,
  output logic [SLOT_BITS-1:0]     slot_data,
  output logic [$clog2(SLOTS)-1:0] slot_idx,
  output logic                     slot_valid,
  output logic                     frame_start,
  output logic                     locked,
  output logic                     frame_err
);

  localparam int BW = $clog2(SLOT_BITS);
  localparam int SW = $clog2(SLOTS);
  localparam int GW = $clog2(LOCK_FRAMES) + 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
  localparam logic [GW-1:0] GOOD_TGT  = GW'(LOCK_FRAMES - 1);
  localparam logic [BW-1:0] BIT_ALIGN =
    (FSYNC_DELAY == 0) ? BW'(1) : '0;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  state_t               r_state;
  logic                 r_lrck_q;
  logic [BW-1:0]        r_bit;
  logic [SW-1:0]        r_slot;
  logic [GW-1:0]        r_good;
  logic [SLOT_BITS-2:0] r_sr;
  logic [SLOT_BITS-1:0] r_slot_data;
  logic [SW-1:0]        r_slot_idx;
  logic                 r_slot_valid;
  logic                 r_frame_start;
  logic                 r_frame_err;

  logic                 w_fs_edge;
  logic                 w_snap;
  logic [BW-1:0]        w_bit;
  logic [SW-1:0]        w_slot;
  logic                 w_exp;
  logic                 w_done;
  logic [SLOT_BITS-1:0] w_word;
  logic [GW-1:0]        w_good_inc;
  logic                 w_lock_hit;
  logic                 w_to_lock;
  logic                 w_emit;

  assign w_fs_edge = lrck & ~r_lrck_q;

  // In DSP mode the edge cycle's own sample is already slot-0 MSB
  assign w_snap = w_fs_edge && (FSYNC_DELAY == 0);
  assign w_bit  = w_snap ? '0 : r_bit;
  assign w_slot = w_snap ? '0 : r_slot;

  assign w_exp = (FSYNC_DELAY == 0)
    ? (r_bit == '0 && r_slot == '0)
    : (r_bit == BIT_LAST && r_slot == SLOT_LAST);

  assign w_done     = (w_bit == BIT_LAST);
  assign w_word     = {r_sr, sdin};
  assign w_good_inc = r_good + GW'(1);
  assign w_lock_hit = (w_good_inc >= GOOD_TGT);

  assign w_to_lock = (r_state == CHECK) && w_fs_edge
                   && w_exp && w_lock_hit;

  assign w_emit = w_done
    && ((r_state == LOCKED) || w_to_lock);

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state       <= HUNT;
      r_lrck_q      <= 1'b0;
      r_bit         <= '0;
      r_slot        <= '0;
      r_good        <= '0;
      r_sr          <= '0;
      r_slot_data   <= '0;
      r_slot_idx    <= '0;
      r_slot_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_lrck_q      <= lrck;
      r_slot_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_err   <= 1'b0;

      if (w_fs_edge) begin
        r_bit  <= BIT_ALIGN;
        r_slot <= '0;
      end else if (r_bit == BIT_LAST) begin
        r_bit  <= '0;
        r_slot <= (r_slot == SLOT_LAST)
          ? '0 : r_slot + SW'(1);
      end else begin
        r_bit <= r_bit + BW'(1);
      end

      if (r_state != HUNT || w_fs_edge)
        r_sr <= w_word[SLOT_BITS-2:0];

      if (w_emit) begin
        r_slot_data   <= w_word;
        r_slot_idx    <= w_slot;
        r_slot_valid  <= 1'b1;
        r_frame_start <= (w_slot == '0);
      end

      unique case (r_state)
        HUNT: begin
          if (w_fs_edge) begin
            r_good  <= '0;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_fs_edge && w_exp) begin
            r_good <= w_good_inc;
            if (w_lock_hit)
              r_state <= LOCKED;
          end else if (w_fs_edge) begin
            r_good <= '0;
          end else if (w_exp) begin
            r_state <= HUNT;
          end
        end
        LOCKED: begin
          // Early edge realigns straight into CHECK; a missing one hunts
          if (w_fs_edge != w_exp) begin
            r_frame_err <= 1'b1;
            r_good      <= '0;
            r_state     <= w_fs_edge ? CHECK : HUNT;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign slot_data   = r_slot_data;
  assign slot_idx    = r_slot_idx;
  assign slot_valid  = r_slot_valid;
  assign frame_start = r_frame_start;
  assign frame_err   = r_frame_err;
  assign locked      = (r_state == LOCKED);

endmodule
